audio_piso_tx: RTL

Parametrised multi-channel audio serializer for the WM8731 DAC path, generalising the fixed-width PISO shift register. It accepts one parallel frame (all channels) per handshake and buffers one frame ahead. It emits the frame bit-serially with frame sync in I2S or left-justified format. It sits between the signal generator / sample source and the codec DACDAT/DACLRC pins, advancing on a bit-clock strobe from the clock-divider block.

---
 rtl/audio_tx_pkg.sv | 8 +
 rtl/slot_shift_reg.sv | 27 ++
 rtl/audio_piso_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/audio_tx_pkg.sv
// Shared types for the multi-channel audio serializer.
// Covers the serial frame format and the controller state.
package audio_tx_pkg;

    typedef enum logic {MODE_I2S, MODE_LJ} tx_mode_e;
    typedef enum logic {S_IDLE, S_RUN} tx_state_e;

endpackage

// File: rtl/slot_shift_reg.sv
// Slot-wide load/shift register driving the serial data pin MSB first.
// A load takes priority over a shift.
module slot_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {q[W-2:0], 1'b0};
    end

    assign msb = q[W-1];

endmodule

// File: rtl/audio_piso_tx.sv
// Multi-channel I2S / left-justified serializer with a one-frame holding buffer.
// state | meaning: S_IDLE | outputs parked, waiting for en & full buffer on a tick; S_RUN | shifting a frame out.
module audio_piso_tx
    import audio_tx_pkg::*;
#(
    parameter int WD     = 24,
    parameter int SLOT_W = 32,
    parameter int NCH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            mode_i,
    input  logic            bit_tick_i,
    input  logic            pdata_valid_i,
    output logic            pdata_ready_o,
    input  logic [NCH*WD-1:0] pdata_i,
    output logic            sdata_o,
    output logic            lrck_o,
    output logic            frame_start_o,
    output logic            underrun_o
);

    localparam int BW = $clog2(SLOT_W);
    localparam int CW = $clog2(NCH);
    localparam int FW = NCH * WD;

    tx_state_e   state_q, state_d;
    tx_mode_e    mode_q, mode_d;
    logic [FW-1:0] buf_q, buf_d, frame_q, frame_d;
    logic        full_q, full_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic        lrck_q, lrck_d, fs_q, fs_d, ur_q, ur_d;

    logic        accept, last_bit, start;
    logic        sr_load, sr_shift;
    logic [WD-1:0] sample;
    logic [SLOT_W-1:0] lj_word, sr_din;

    assign accept = pdata_valid_i && !full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        buf_d     = buf_q;
        full_d    = full_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        lrck_d    = lrck_q;
        fs_d      = 1'b0;
        ur_d      = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sample    = '0;

        last_bit = (bit_cnt_q == BW'(SLOT_W - 1)) && (ch_cnt_q == CW'(NCH - 1));
        start    = bit_tick_i && en_i && ((state_q == S_IDLE) ? full_q : last_bit);

        if (start) begin
            // An empty buffer still starts a frame on time, just with silence.
            state_d   = S_RUN;
            mode_d    = tx_mode_e'(mode_i);
            bit_cnt_d = '0;
            ch_cnt_d  = '0;
            frame_d   = full_q ? buf_q : '0;
            full_d    = 1'b0;
            fs_d      = 1'b1;
            ur_d      = !full_q;
            sample    = frame_d[WD-1:0];
            sr_load   = 1'b1;
            lrck_d    = (mode_d == MODE_LJ);
        end else if (bit_tick_i && state_q == S_RUN) begin
            if (last_bit) begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                ch_cnt_d  = '0;
                sr_load   = 1'b1;
                lrck_d    = (mode_q == MODE_LJ);
            end else if (bit_cnt_q == BW'(SLOT_W - 1)) begin
                bit_cnt_d = '0;
                ch_cnt_d  = ch_cnt_q + CW'(1);
                sample    = frame_q[int'(ch_cnt_d)*WD +: WD];
                sr_load   = 1'b1;
                lrck_d    = (ch_cnt_d >= CW'(NCH / 2)) ^ (mode_q == MODE_LJ);
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                sr_shift  = 1'b1;
            end
        end

        // Accept only happens with the buffer empty, so it never collides with a transfer.
        if (accept) begin
            full_d = 1'b1;
            buf_d  = pdata_i;
        end

        lj_word = SLOT_W'(sample) << (SLOT_W - WD);
        sr_din  = (mode_d == MODE_I2S) ? (lj_word >> 1) : lj_word;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q    <= MODE_I2S;
            buf_q     <= '0;
            full_q    <= 1'b0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            ch_cnt_q  <= '0;
            lrck_q    <= 1'b0;
            fs_q      <= 1'b0;
            ur_q      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            lrck_q    <= lrck_d;
            fs_q      <= fs_d;
            ur_q      <= ur_d;
        end
    end

    slot_shift_reg #(.W(SLOT_W)) u_shift (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (sr_load),
        .shift  (sr_shift),
        .din    (sr_din),
        .msb    (sdata_o)
    );

    assign pdata_ready_o = !full_q;
    assign lrck_o        = lrck_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;

endmodule
